// File: rtl/ccff_loader.sv
// Serial loader for the fabric configuration flip-flop chain: accepts words, shifts CHAIN_LEN bits MSB-first.
// Optional CRC-16 readback of the chain is enabled with `define CCFF_LOADER_READBACK_EN.
module ccff_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WORD_W-1:0] word_data,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             config_done,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

`ifdef CCFF_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [WORD_W-1:0] sreg_r, sreg_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [IDX_W-1:0]  idx_r, idx_s;

`ifdef CCFF_LOADER_READBACK_EN
  logic [15:0] crc_in_r, crc_in_s;
  logic [15:0] crc_out_r, crc_out_s;
  logic [15:0] crc_out_final_s;

  // One bit of CRC-16-CCITT (poly 0x1021), data fed MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      sreg_r    <= '0;
      cnt_r     <= '0;
      idx_r     <= '0;
`ifdef CCFF_LOADER_READBACK_EN
      crc_in_r  <= 16'hFFFF;
      crc_out_r <= 16'hFFFF;
`endif
    end else begin
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
`ifdef CCFF_LOADER_READBACK_EN
      crc_in_r  <= crc_in_s;
      crc_out_r <= crc_out_s;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
`ifdef CCFF_LOADER_READBACK_EN
    crc_in_s        = crc_in_r;
    crc_out_s       = crc_out_r;
    crc_out_final_s = crc16_step(crc_out_r, ccff_tail);
`endif
    case (state_r)
      S_IDLE, S_DONE
`ifdef CCFF_LOADER_READBACK_EN
      , S_ERROR
`endif
      : begin
        if (start) begin
          state_s = S_LOAD;
          cnt_s   = '0;
          idx_s   = '0;
`ifdef CCFF_LOADER_READBACK_EN
          crc_in_s  = 16'hFFFF;
          crc_out_s = 16'hFFFF;
`endif
        end else begin
          state_s = state_r;
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          sreg_s  = word_data;
          idx_s   = '0;
          state_s = S_SHIFT;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_SHIFT: begin
        sreg_s = sreg_r << 1;
        cnt_s  = cnt_r + CNT_W'(1);
        idx_s  = idx_r + IDX_W'(1);
`ifdef CCFF_LOADER_READBACK_EN
        crc_in_s = crc16_step(crc_in_r, sreg_r[WORD_W-1]);
`endif
        // Chain length wins over word boundary: leftover bits of the last word are dropped.
        if (cnt_r == LAST_BIT) begin
`ifdef CCFF_LOADER_READBACK_EN
          state_s = S_VERIFY;
          cnt_s   = '0;
`else
          state_s = S_DONE;
`endif
        end else if (idx_r == LAST_IDX) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_SHIFT;
        end
      end
`ifdef CCFF_LOADER_READBACK_EN
      S_VERIFY: begin
        cnt_s     = cnt_r + CNT_W'(1);
        crc_out_s = crc_out_final_s;
        if (cnt_r == LAST_BIT) begin
          state_s = (crc_out_final_s == crc_in_r) ? S_DONE : S_ERROR;
        end else begin
          state_s = S_VERIFY;
        end
      end
`endif
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  assign bit_count   = cnt_r;
  assign word_ready  = (state_r == S_LOAD);
  assign config_done = (state_r == S_DONE);

`ifdef CCFF_LOADER_READBACK_EN
  assign ccff_shift_en = (state_r == S_SHIFT) || (state_r == S_VERIFY);
  // During readback the chain recirculates so its contents survive verification.
  assign ccff_head     = (state_r == S_VERIFY) ? ccff_tail :
                         ((state_r == S_SHIFT) ? sreg_r[WORD_W-1] : 1'b0);
  assign busy          = (state_r == S_LOAD) || (state_r == S_SHIFT) || (state_r == S_VERIFY);
  assign error         = (state_r == S_ERROR);
`else
  assign ccff_shift_en = (state_r == S_SHIFT);
  assign ccff_head     = (state_r == S_SHIFT) ? sreg_r[WORD_W-1] : 1'b0;
  assign busy          = (state_r == S_LOAD) || (state_r == S_SHIFT);
  assign error         = 1'b0;
`endif

endmodule
